// File: rtl/adc_dac_pkg.sv
// adc_dac_pkg: shared types and constants for the adc-dac subsystem
package adc_dac_pkg;
  localparam int DAC_W = 14;
  localparam int ADC_W = 12;
  localparam logic [DAC_W-1:0] MIDSCALE = 14'h2000;
  typedef struct packed {
    logic [DAC_W-1:0] ch2;
    logic [DAC_W-1:0] ch1;
  } sample_pair_t;
  typedef enum logic {IDLE, PLAY} state_e;
endpackage

// File: rtl/wave_ram.sv
// wave_ram: simple dual-port sample RAM, registered read, old data on same-address collision
module wave_ram #(
  parameter int AW = 10,
  parameter int DW = 28
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  // write and read share the edge; the read sees the pre-write contents
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/dac_wave_player.sv
// dac_wave_player: plays a dual-channel sample RAM into the AN9767 DAC bus; DAC_WAVE_PLAYER_OFFSET_BIN_EN selects offset-binary output
module dac_wave_player
  import adc_dac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14,
  parameter int DIV_W  = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [2*DATA_W-1:0]   wr_data_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  input  logic [ADDR_W-1:0]     len_m1_i,
  input  logic [DIV_W-1:0]      rate_div_i,
  output logic [DATA_W-1:0]     dac1_data_o,
  output logic [DATA_W-1:0]     dac2_data_o,
  output logic                  sample_stb_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef DAC_WAVE_PLAYER_OFFSET_BIN_EN
  localparam logic [DATA_W-1:0] FLIP = MSB;
`else
  localparam logic [DATA_W-1:0] FLIP = '0;
`endif
  state_e              state_q;
  logic [ADDR_W-1:0]   rd_addr_q, len_q;
  logic [DIV_W-1:0]    div_q, rate_q;
  logic                rd_vld_q, rd_last_q;
  logic [2*DATA_W-1:0] rdata;
  logic                tick, last, kill;
  assign tick = (state_q == PLAY) && (div_q == rate_q);
  assign last = rd_addr_q == len_q;
  // a stop, or a restart during playback, drops every read still in the pipeline
  assign kill = stop_i | (start_i & (state_q == PLAY));
  assign busy_o = (state_q == PLAY) | rd_vld_q | sample_stb_o;
  wave_ram #(.AW(ADDR_W), .DW(2*DATA_W)) u_ram (
    .clk_i   (sys_clk_i),
    .we_i    (wr_en_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .re_i    (tick),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata)
  );
  // playback FSM: shadows latched on start, divider paces the read ticks
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      div_q     <= '0;
      len_q     <= '0;
      rate_q    <= '0;
    end else if (stop_i) begin
      state_q <= IDLE;
    end else if (start_i) begin
      state_q   <= PLAY;
      len_q     <= len_m1_i;
      rate_q    <= rate_div_i;
      rd_addr_q <= '0;
      div_q     <= '0;
    end else if (tick) begin
      div_q     <= '0;
      rd_addr_q <= last ? '0 : rd_addr_q + ADDR_W'(1);
      if (last && !loop_en_i) state_q <= IDLE;
    end else if (state_q == PLAY) begin
      div_q <= div_q + DIV_W'(1);
    end
  end
  // read-valid stage then output register stage; outputs hold until the next valid sample
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      sample_stb_o <= 1'b0;
      done_o       <= 1'b0;
      dac1_data_o  <= FLIP;
      dac2_data_o  <= FLIP;
    end else begin
      rd_vld_q     <= tick & ~kill;
      rd_last_q    <= tick & last & ~loop_en_i;
      sample_stb_o <= rd_vld_q & ~kill;
      done_o       <= rd_vld_q & rd_last_q & ~kill;
      if (rd_vld_q && !kill) begin
        dac1_data_o <= rdata[DATA_W-1:0] ^ FLIP;
        dac2_data_o <= rdata[2*DATA_W-1:DATA_W] ^ FLIP;
      end
    end
  end
endmodule

// File: tb/tb_dac_wave_player.sv
// tb_dac_wave_player: directed stimulus with a cycle-stamped scoreboard of expected strobes
module tb_dac_wave_player;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [27:0] wr_data = '0;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [9:0]  len_m1 = '0;
  logic [15:0] rate_div = '0;
  logic [13:0] dac1, dac2;
  logic        stb, busy, done;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          s0, s1;
  logic [13:0] c1 [6];
  logic [13:0] c2 [6];
  typedef struct {
    logic [13:0] d1;
    logic [13:0] d2;
    logic        dn;
    int          at;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic        exp_stb;

  dac_wave_player dut (
    .sys_clk_i    (clk),
    .rst_n_i      (rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .start_i      (start),
    .stop_i       (stop),
    .loop_en_i    (loop_en),
    .len_m1_i     (len_m1),
    .rate_div_i   (rate_div),
    .dac1_data_o  (dac1),
    .dac2_data_o  (dac2),
    .sample_stb_o (stb),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] cv(logic [13:0] x);
`ifdef DAC_WAVE_PLAYER_OFFSET_BIN_EN
    return x ^ 14'h2000;
`else
    return x;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int a, logic dn, int at);
    sb.push_back('{cv(c1[a]), cv(c2[a]), dn, at});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  // every falling edge: a strobe must appear exactly when the scoreboard head is due
  always @(negedge clk) begin
    if (rst_n) begin
      exp_stb = (sb.size() > 0) && (sb[0].at == cyc);
      chk("stb", {31'd0, stb}, {31'd0, exp_stb});
      if (exp_stb) begin
        e = sb.pop_front();
        chk("dac1", {18'd0, dac1}, {18'd0, e.d1});
        chk("dac2", {18'd0, dac2}, {18'd0, e.d2});
        chk("done", {31'd0, done}, {31'd0, e.dn});
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
      end
    end
  end

  initial begin
    c1[0] = 14'd100; c2[0] = 14'd1;
    c1[1] = 14'd200; c2[1] = 14'd2;
    c1[2] = 14'd300; c2[2] = 14'd3;
    c1[3] = 14'd400; c2[3] = 14'd4;
    c1[4] = 14'h3FFF; c2[4] = 14'h0000;
    c1[5] = 14'h0000; c2[5] = 14'h3FFF;
    step(2);
    chk("rst_dac1", {18'd0, dac1}, {18'd0, cv(14'd0)});
    chk("rst_dac2", {18'd0, dac2}, {18'd0, cv(14'd0)});
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_addr = 10'(i);
      wr_data = {c2[i], c1[i]};
      step(1);
    end
    wr_en = 1'b0;
    step(2);

    // one-shot, one sample per clock
    len_m1 = 10'd3; rate_div = 16'd0; loop_en = 1'b0;
    s0 = cyc;
    for (int n = 0; n < 4; n++) push(n, n == 3, s0 + 3 + n);
    pulse_start();
    step(1);
    chk("busy_play", {31'd0, busy}, 32'd1);
    step(4);
    chk("busy_last_stb", {31'd0, busy}, 32'd1);
    step(1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    step(3);

    // looped at rate 5, shadow regs ignore later edits, then loop released
    len_m1 = 10'd3; rate_div = 16'd4; loop_en = 1'b1;
    s0 = cyc;
    for (int n = 0; n < 8; n++) push(n % 4, n == 7, s0 + 7 + 5 * n);
    pulse_start();
    rate_div = 16'd1; len_m1 = 10'd0;
    step(31);
    loop_en = 1'b0;
    step(10);
    chk("busy_loop_end", {31'd0, busy}, 32'd1);
    step(1);
    chk("busy_loop_done", {31'd0, busy}, 32'd0);
    step(3);

    // stop while the second read is in flight
    len_m1 = 10'd3; rate_div = 16'd4; loop_en = 1'b0;
    s0 = cyc;
    push(0, 1'b0, s0 + 7);
    pulse_start();
    step(10);
    pulse_stop();
    step(1);
    chk("busy_stop", {31'd0, busy}, 32'd0);
    chk("hold_stop", {18'd0, dac1}, {18'd0, cv(14'd100)});
    step(3);

    // start with stop in IDLE, then restart mid-play with a read in flight
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    step(8);
    chk("busy_start_stop", {31'd0, busy}, 32'd0);
    len_m1 = 10'd3; rate_div = 16'd4; loop_en = 1'b1;
    s0 = cyc;
    push(0, 1'b0, s0 + 7);
    push(1, 1'b0, s0 + 12);
    pulse_start();
    step(15);
    s1 = cyc;
    push(0, 1'b0, s1 + 7);
    pulse_start();
    step(7);
    pulse_stop();
    step(3);
    chk("busy_restart", {31'd0, busy}, 32'd0);
    chk("hold_restart", {18'd0, dac1}, {18'd0, cv(14'd100)});

    // asynchronous reset between edges during playback
    len_m1 = 10'd3; rate_div = 16'd0; loop_en = 1'b1;
    s0 = cyc;
    for (int n = 0; n < 5; n++) push(n % 4, 1'b0, s0 + 3 + n);
    pulse_start();
    step(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dac1", {18'd0, dac1}, {18'd0, cv(14'd0)});
    chk("arst_dac2", {18'd0, dac2}, {18'd0, cv(14'd0)});
    chk("arst_stb", {31'd0, stb}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("busy_after_arst", {31'd0, busy}, 32'd0);

    // extreme codes, one-shot over six samples
    len_m1 = 10'd5; rate_div = 16'd0; loop_en = 1'b0;
    s0 = cyc;
    for (int n = 0; n < 6; n++) push(n, n == 5, s0 + 3 + n);
    pulse_start();
    step(10);
    chk("hold_final", {18'd0, dac1}, {18'd0, cv(14'h0000)});
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
